// File: rtl/vga_plot_pkg.sv
// Shared VGA pixel types and screen geometry for the drawing blocks
// (circle, fillscreen, plot queue).
package vga_plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_t;

    // Signed bounds test: the drawer emits raw octant points that may fall off-screen.
    function automatic logic on_screen(input logic signed [8:0] x, input logic signed [7:0] y);
        return (int'(x) >= 0) && (int'(x) < SCREEN_W) && (int'(y) >= 0) && (int'(y) < SCREEN_H);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot_t entries with occupancy-derived full/empty flags.
// The read data is the current head entry, shown combinationally.
module plot_fifo
    import vga_plot_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  plot_t din,
    input  logic  pop,
    output plot_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    plot_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: storage has no reset; contents are only read once the count says they are valid,
    // so resetting the array would just cost a wide reset net for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_plot_queue.sv
// Clips signed plot requests to the VGA window, buffers visible pixels and
// streams them to the adapter, reporting frame completion once drained.
module vga_plot_queue
    import vga_plot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_x,
    input  logic [7:0]       in_y,
    input  logic [2:0]       in_colour,
    input  logic             in_done,
    input  logic             out_stall,
    output logic [7:0]       vga_x,
    output logic [6:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    output logic             all_done,
    output logic [CNT_W-1:0] clipped_count,
    output logic             empty,
    output logic             full
);

    logic  visible;
    logic  handshake;
    logic  push;
    logic  pop;
    logic  done_pending;
    plot_t wr_data;
    plot_t head;

    assign visible   = on_screen($signed(in_x), $signed(in_y));
    assign in_ready  = !full;
    assign handshake = in_valid && in_ready;
    assign push      = handshake && visible;
    assign pop       = !out_stall && !empty;

    assign wr_data.x      = in_x[7:0];
    assign wr_data.y      = in_y[6:0];
    assign wr_data.colour = in_colour;

    plot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
            clipped_count <= '0;
            done_pending  <= 1'b0;
        end else begin
            vga_plot <= pop;
            if (pop) begin
                vga_x      <= head.x;
                vga_y      <= head.y;
                vga_colour <= head.colour;
            end
            if (handshake && !visible && (clipped_count != '1)) begin
                clipped_count <= clipped_count + CNT_W'(1);
            end
            // in_done wins over a same-cycle handshake so done lands after that pixel.
            if (in_done) begin
                done_pending <= 1'b1;
            end else if (handshake) begin
                done_pending <= 1'b0;
            end
        end
    end

    assign all_done = done_pending && empty && !vga_plot;

endmodule
